// File: rtl/spi_slave.sv
// SPI mode-0 slave with a single-entry transmit buffer.
// All pins are synchronized into clk; edges are detected on the synchronized SCK.
module spi_slave #(
   parameter logic [7:0] DUMMY_BYTE = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       SCK,
   input  logic       SS_N,
   input  logic       MOSI,
   output logic       MISO,
   output logic       miso_oe,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       underrun,
   output logic       busy
);

   typedef enum logic [1:0] {StIdle, StLoad, StShift} state_e;

   state_e     state_q, state_d;
   logic       sck_s1_q, sck_s2_q, sck_d3_q;
   logic       ss_s1_q, ss_s2_q, ss_d3_q;
   logic       mosi_s1_q, mosi_s2_q;
   logic [7:0] tx_shift_q, tx_shift_d;
   logic [7:0] rx_shift_q, rx_shift_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic       skip_fall_q, skip_fall_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       underrun_q, underrun_d;
   logic       buf_full_q, buf_full_d;
   logic [7:0] buf_q, buf_d;
   logic       sck_rise, sck_fall, ss_fall, load;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sck_s1_q  <= 1'b0;
         sck_s2_q  <= 1'b0;
         sck_d3_q  <= 1'b0;
         ss_s1_q   <= 1'b1;
         ss_s2_q   <= 1'b1;
         ss_d3_q   <= 1'b1;
         mosi_s1_q <= 1'b0;
         mosi_s2_q <= 1'b0;
      end else begin
         sck_s1_q  <= SCK;
         sck_s2_q  <= sck_s1_q;
         sck_d3_q  <= sck_s2_q;
         ss_s1_q   <= SS_N;
         ss_s2_q   <= ss_s1_q;
         ss_d3_q   <= ss_s2_q;
         mosi_s1_q <= MOSI;
         mosi_s2_q <= mosi_s1_q;
      end
   end

   assign sck_rise = sck_s2_q & ~sck_d3_q;
   assign sck_fall = ~sck_s2_q & sck_d3_q;
   assign ss_fall  = ss_d3_q & ~ss_s2_q;

   always_comb begin
      state_d     = state_q;
      tx_shift_d  = tx_shift_q;
      rx_shift_d  = rx_shift_q;
      bit_cnt_d   = bit_cnt_q;
      skip_fall_d = skip_fall_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      underrun_d  = 1'b0;
      buf_full_d  = buf_full_q;
      buf_d       = buf_q;
      load        = 1'b0;
      unique case (state_q)
         StIdle: begin
            bit_cnt_d   = 3'd0;
            skip_fall_d = 1'b0;
            tx_shift_d  = 8'h00;
            if (ss_fall) state_d = StLoad;
         end
         StLoad: begin
            if (ss_s2_q) begin
               state_d = StIdle;
            end else begin
               load        = 1'b1;
               bit_cnt_d   = 3'd0;
               skip_fall_d = 1'b0;
               rx_shift_d  = 8'h00;
               state_d     = StShift;
            end
         end
         StShift: begin
            if (ss_s2_q) begin
               state_d   = StIdle;
               bit_cnt_d = 3'd0;
            end else if (sck_rise) begin
               rx_shift_d = {rx_shift_q[6:0], mosi_s2_q};
               bit_cnt_d  = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  rx_data_d   = {rx_shift_q[6:0], mosi_s2_q};
                  rx_valid_d  = 1'b1;
                  load        = 1'b1;
                  skip_fall_d = 1'b1;
               end
            end else if (sck_fall) begin
               // The fall right after a byte boundary must keep the freshly loaded MSB.
               if (skip_fall_q) skip_fall_d = 1'b0;
               else             tx_shift_d  = {tx_shift_q[6:0], 1'b0};
            end
         end
         default: state_d = StIdle;
      endcase
      if (load) begin
         if (buf_full_q) begin
            tx_shift_d = buf_q;
            buf_full_d = 1'b0;
         end else begin
            tx_shift_d = DUMMY_BYTE;
            underrun_d = 1'b1;
         end
      end
      if (tx_valid && !buf_full_q) begin
         buf_d      = tx_data;
         buf_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         tx_shift_q  <= 8'h00;
         rx_shift_q  <= 8'h00;
         bit_cnt_q   <= 3'd0;
         skip_fall_q <= 1'b0;
         rx_data_q   <= 8'h00;
         rx_valid_q  <= 1'b0;
         underrun_q  <= 1'b0;
         buf_full_q  <= 1'b0;
         buf_q       <= 8'h00;
      end else begin
         state_q     <= state_d;
         tx_shift_q  <= tx_shift_d;
         rx_shift_q  <= rx_shift_d;
         bit_cnt_q   <= bit_cnt_d;
         skip_fall_q <= skip_fall_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         underrun_q  <= underrun_d;
         buf_full_q  <= buf_full_d;
         buf_q       <= buf_d;
      end
   end

   assign busy     = (state_q != StIdle);
   assign MISO     = busy & tx_shift_q[7];
   assign miso_oe  = busy & ~ss_s2_q;
   assign tx_ready = ~buf_full_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: table of transfers plus randomized transfers, checked against a
// byte-level model of the transmit buffer and receive stream.
module tb_spi_slave;

   localparam logic [7:0] DUMMY = 8'h00;

   logic       clk, reset, SCK, SS_N, MOSI, MISO, miso_oe;
   logic [7:0] tx_data, rx_data;
   logic       tx_valid, tx_ready, rx_valid, underrun, busy;

   int n_pass  = 0;
   int n_total = 0;
   int rx_cnt  = 0;
   int un_cnt  = 0;
   logic [7:0] rx_q[$];

   typedef struct {
      int              n;
      bit              pre;
      logic [7:0]      pv;
      logic [3:0][7:0] mo;
      logic [3:0]      pu;
      logic [3:0][7:0] pd;
   } xfer_t;

   xfer_t tbl[4];

   spi_slave #(.DUMMY_BYTE(DUMMY)) dut (
      .clk      (clk),
      .reset    (reset),
      .SCK      (SCK),
      .SS_N     (SS_N),
      .MOSI     (MOSI),
      .MISO     (MISO),
      .miso_oe  (miso_oe),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .underrun (underrun),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rx_valid) begin
         rx_cnt++;
         rx_q.push_back(rx_data);
      end
      if (underrun) un_cnt++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h required %0h", name, act, exp);
   endtask

   task automatic push_tx(input logic [7:0] d);
      int w = 0;
      while (!tx_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      check("tx_ready_before_push", {31'd0, tx_ready}, 32'd1);
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      check("tx_ready_after_push", {31'd0, tx_ready}, 32'd0);
   endtask

   // One mode-0 byte at clk/8; optionally refills the buffer mid-byte.
   task automatic spi_byte(input logic [7:0] mo, input bit push, input logic [7:0] pd,
                           output logic [7:0] mi);
      for (int i = 7; i >= 0; i--) begin
         MOSI = mo[i];
         repeat (4) @(negedge clk);
         mi[i] = MISO;
         SCK = 1'b1;
         if (push && i == 4) begin
            push_tx(pd);
            repeat (3) @(negedge clk);
         end else begin
            repeat (4) @(negedge clk);
         end
         SCK = 1'b0;
      end
   endtask

   task automatic run_xfer(input xfer_t x);
      logic [7:0] exp_q[$];
      logic [7:0] mi;
      int         exp_un = 0;
      bit         pend;
      logic [7:0] pval;
      int         rx0, un0;
      // Model: every byte boundary (including select) takes the buffer or the dummy byte.
      pend = x.pre;
      pval = x.pv;
      exp_q.push_back(pend ? pval : DUMMY);
      if (!pend) exp_un++;
      pend = 1'b0;
      for (int k = 0; k < x.n; k++) begin
         if (x.pu[k]) begin
            pend = 1'b1;
            pval = x.pd[k];
         end
         exp_q.push_back(pend ? pval : DUMMY);
         if (!pend) exp_un++;
         pend = 1'b0;
      end

      if (x.pre) push_tx(x.pv);
      rx0 = rx_cnt;
      un0 = un_cnt;
      rx_q.delete();
      SS_N = 1'b0;
      repeat (8) @(negedge clk);
      check("busy_selected", {31'd0, busy}, 32'd1);
      check("miso_oe_selected", {31'd0, miso_oe}, 32'd1);
      check("tx_ready_after_load", {31'd0, tx_ready}, 32'd1);
      for (int k = 0; k < x.n; k++) begin
         spi_byte(x.mo[k], x.pu[k], x.pd[k], mi);
         check("miso_byte", {24'd0, mi}, {24'd0, exp_q[k]});
      end
      repeat (4) @(negedge clk);
      SS_N = 1'b1;
      repeat (6) @(negedge clk);
      check("busy_deselected", {31'd0, busy}, 32'd0);
      check("miso_oe_deselected", {30'd0, miso_oe, MISO}, 32'd0);
      check("rx_valid_count", rx_cnt - rx0, x.n);
      for (int k = 0; k < x.n; k++)
         check("rx_byte", (k < rx_q.size()) ? {24'd0, rx_q[k]} : 32'hDEAD, {24'd0, x.mo[k]});
      check("underrun_count", un_cnt - un0, exp_un);
   endtask

   initial begin
      xfer_t      r;
      int         rx0;
      logic [7:0] d;

      tbl[0] = '{n: 1, pre: 1, pv: 8'hA5, mo: {24'h0, 8'h3C}, pu: 4'b0000, pd: 32'h0};
      tbl[1] = '{n: 2, pre: 1, pv: 8'h33, mo: {16'h0, 8'h7E, 8'h81}, pu: 4'b0011,
                 pd: {16'h0, 8'h99, 8'h55}};
      tbl[2] = '{n: 1, pre: 0, pv: 8'h00, mo: {24'h0, 8'hC3}, pu: 4'b0000, pd: 32'h0};
      tbl[3] = '{n: 3, pre: 0, pv: 8'h00, mo: {8'h0, 8'h5A, 8'h00, 8'hFF}, pu: 4'b0001,
                 pd: {24'h0, 8'h12}};

      SCK = 1'b0; SS_N = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; reset = 1'b0;
      #1;
      check("reset_miso", {31'd0, MISO}, 32'd0);
      check("reset_miso_oe", {31'd0, miso_oe}, 32'd0);
      check("reset_rx_data", {24'd0, rx_data}, 32'd0);
      check("reset_flags", {29'd0, rx_valid, underrun, busy}, 32'd0);
      check("reset_tx_ready", {31'd0, tx_ready}, 32'd1);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);

      for (int t = 0; t < 4; t++) run_xfer(tbl[t]);

      // Abort after five SCK rising edges.
      rx0 = rx_cnt;
      SS_N = 1'b0;
      repeat (8) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         MOSI = 1'($urandom);
         repeat (4) @(negedge clk);
         SCK = 1'b1;
         repeat (4) @(negedge clk);
         SCK = 1'b0;
      end
      repeat (2) @(negedge clk);
      SS_N = 1'b1;
      repeat (3) @(negedge clk);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_no_rx_valid", rx_cnt - rx0, 0);
      repeat (4) @(negedge clk);
      r = '{n: 1, pre: 1, pv: 8'(($urandom)), mo: {24'h0, 8'hF0}, pu: 4'b0000, pd: 32'h0};
      run_xfer(r);

      // SCK activity while deselected.
      rx0 = rx_cnt;
      for (int i = 0; i < 8; i++) begin
         MOSI = 1'($urandom);
         SCK = ~SCK;
         repeat (4) @(negedge clk);
      end
      check("idle_sck_no_rx_valid", rx_cnt - rx0, 0);
      check("idle_sck_pins", {29'd0, MISO, miso_oe, busy}, 32'd0);

      // Reset in the middle of a byte.
      rx0 = rx_cnt;
      SS_N = 1'b0;
      repeat (8) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         MOSI = 1'b1;
         repeat (4) @(negedge clk);
         SCK = 1'b1;
         repeat (4) @(negedge clk);
         SCK = 1'b0;
      end
      MOSI = 1'b1;
      repeat (4) @(negedge clk);
      SCK = 1'b1;
      #2;
      reset = 1'b0;
      #1;
      check("midreset_miso", {30'd0, MISO, miso_oe}, 32'd0);
      check("midreset_rx_data", {24'd0, rx_data}, 32'd0);
      check("midreset_flags", {29'd0, rx_valid, underrun, busy}, 32'd0);
      check("midreset_tx_ready", {31'd0, tx_ready}, 32'd1);
      SCK = 1'b0;
      SS_N = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (4) @(negedge clk);
      check("midreset_no_rx_valid", rx_cnt - rx0, 0);

      for (int t = 0; t < 12; t++) begin
         r.n   = int'($urandom_range(1, 4));
         r.pre = 1'($urandom);
         d     = 8'($urandom);
         r.pv  = d;
         r.mo  = $urandom;
         r.pu  = 4'($urandom);
         r.pd  = $urandom;
         run_xfer(r);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Parameters
REQ-001 SHALL provide parameter DUMMY_BYTE, default 8'h00: byte shifted out on MISO when no transmit data is buffered at a byte boundary.

Interface
REQ-002 SHALL have port clk, input, 1: system clock; all logic on rising edge.
REQ-003 SHALL have port reset, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port SCK, input, 1: SPI shift clock from master, asynchronous to clk, idle low.
REQ-005 SHALL have port SS_N, input, 1: slave select, active-low, asynchronous.
REQ-006 SHALL have port MOSI, input, 1: serial data from master, MSB first.
REQ-007 SHALL have port MISO, output, 1: serial data to master, MSB first.
REQ-008 SHALL have port miso_oe, output, 1: MISO output enable, high while selected.
REQ-009 SHALL have port tx_data, input, 8: next byte to transmit.
REQ-010 SHALL have port tx_valid, input, 1: tx_data valid; capture when tx_valid & tx_ready.
REQ-011 SHALL have port tx_ready, output, 1: transmit buffer empty.
REQ-012 SHALL have port rx_data, output, 8: last fully received byte.
REQ-013 SHALL have port rx_valid, output, 1: one-clk pulse when rx_data updates.
REQ-014 SHALL have port underrun, output, 1: one-clk pulse when DUMMY_BYTE is loaded because the buffer is empty.
REQ-015 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-016 SHALL implement SPI mode 0 only: MOSI sampled on SCK rising edge, MISO updated on SCK falling edge.
REQ-017 SHALL pass SCK, SS_N and MOSI through 2-flop synchronizers; edges are detected on synchronized SCK. Pin-to-action latency is 3 clk. Supported SCK frequency is at most clk/8.
REQ-018 SHALL implement the state machine IDLE -> LOAD -> SHIFT.
  - IDLE -> LOAD: on synchronized SS_N falling.
  - LOAD -> SHIFT: after one clk.
  - SHIFT -> IDLE: on synchronized SS_N high, from any state.
REQ-019 SHALL, in LOAD, perform the following:
  - load tx_shift from the buffer if the buffer is full, otherwise from DUMMY_BYTE and pulse underrun;
  - mark the buffer empty;
  - clear bit_cnt (3 bits) and skip_fall.
REQ-020 SHALL, on SCK rising in SHIFT, shift the synchronized MOSI into the rx_shift LSB and increment bit_cnt (wraps 7 -> 0).
REQ-021 SHALL, on the rising edge where bit_cnt is 7, perform the following:
  - write {rx_shift[6:0], MOSI} to rx_data and pulse rx_valid for 1 clk;
  - reload tx_shift per REQ-019 (buffer or DUMMY_BYTE plus underrun);
  - set skip_fall.
REQ-022 SHALL, on SCK falling in SHIFT, perform the following:
  - if skip_fall is set, clear it without shifting;
  - otherwise shift tx_shift left by 1.
REQ-023 SHALL drive MISO from tx_shift[7] and miso_oe from ~SS_N (synchronized) while busy; both SHALL be 0 in IDLE.
REQ-024 SHALL make tx_ready = ~buffer_full. On a cycle with tx_valid & tx_ready, the buffer captures tx_data and tx_ready drops the next clk.
REQ-025 SHALL evaluate a buffer load (REQ-019/021) against buffer contents at the start of the cycle. If the buffer is empty, DUMMY_BYTE is sent and a simultaneous tx_valid capture fills the buffer for the next byte.
REQ-026 SHALL, on SS_N rising mid-byte, perform the following:
  - discard the partial rx_shift;
  - raise no rx_valid;
  - clear bit_cnt;
  - return to IDLE;
  - leave the buffer contents unchanged.
REQ-027 SHALL ignore SCK edges and MOSI while in IDLE.
REQ-028 SHALL treat rx_valid as advisory only: there is no backpressure, and a new byte overwrites rx_data.

Reset
REQ-029 SHALL, on reset low, asynchronously force the following:
  - state IDLE; MISO 0; miso_oe 0;
  - rx_data 8'h00; rx_valid 0; underrun 0; busy 0; tx_ready 1;
  - bit_cnt 0; skip_fall 0; buffer empty; synchronizers to SCK=0, SS_N=1, MOSI=0.
REQ-030 SHALL abort any transfer on reset assertion mid-byte, with no rx_valid pulse.

Verification
REQ-031 SHALL pass this case: load tx 8'hA5, then master sends 8'h3C, clk:SCK = 8:1 → MISO bits 1,0,1,0,0,1,0,1; rx_data 8'h3C with one rx_valid pulse; tx_ready high after LOAD.
REQ-032 SHALL pass this case: two back-to-back bytes 8'h81, 8'h7E with buffer refilled with 8'h55 before the boundary → rx_valid twice; second MISO byte 8'h55; no underrun.
REQ-033 SHALL pass this case: empty buffer at SS_N fall, DUMMY_BYTE=8'h00 → underrun pulse; MISO byte 8'h00; rx still correct.
REQ-034 SHALL pass this case: SS_N rises after 5 SCK rising edges → no rx_valid; busy 0 within 3 clk; next transfer of 8'hF0 received correctly.
REQ-035 SHALL pass this case: SCK toggles 8 times with SS_N high → no rx_valid; MISO 0; miso_oe 0.
REQ-036 SHALL pass this case: reset asserted mid-byte → all outputs at REQ-029 values immediately; tx_ready 1.
